// File: rtl/arp_requester.sv
`default_nettype none
// ============================================================================
// Module   : arp_requester
// Purpose  : ARP initiator. On a start pulse, broadcasts an ARP request for
//            target_ip on a 64-bit AXI-Stream egress, then watches the
//            ingress stream for the matching ARP reply. Retries on timeout
//            and reports either the resolved MAC (done) or failure (error).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   bus_clk, bus_rst          clock, synchronous active-high reset
//   my_mac, my_ip, target_ip  local addresses and address to resolve
//                             (byte 0 in the most significant bits)
//   start                     request pulse, honoured only when idle
//   busy, done, error         status; done/error are one-cycle pulses
//   resolved_mac              last MAC resolved by a successful request
//   m_axis_*                  request frame egress (60 bytes, 8 beats)
//   s_axis_*                  received frame ingress (always ready)
// Parameters
//   TIMEOUT      cycles to wait for a reply after a request's last beat
//   MAX_RETRIES  extra transmissions after the first (0..255)
// ============================================================================
module arp_requester #(
    parameter int TIMEOUT     = 1000000,
    parameter int MAX_RETRIES = 3
) (
    input  logic        bus_clk,
    input  logic        bus_rst,
    input  logic [47:0] my_mac,
    input  logic [31:0] my_ip,
    input  logic [31:0] target_ip,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [47:0] resolved_mac,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready
);

    localparam int              c_tw          = $clog2(TIMEOUT);
    localparam logic [c_tw-1:0] c_timer_last  = c_tw'(TIMEOUT - 1);
    localparam logic [7:0]      c_max_retries = 8'(MAX_RETRIES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          r_state;
    logic [47:0]     r_my_mac;
    logic [31:0]     r_my_ip;
    logic [31:0]     r_target_ip;
    logic [7:0]      r_attempts;
    logic [c_tw-1:0] r_timer;
    logic [2:0]      r_tx_beat;

    // Rx header fields, captured from the beat that carries them.
    logic [7:0]      r_rx_idx;
    logic [31:0]     r_f1;      // bytes 12-15
    logic [63:0]     r_f2;      // bytes 16-23
    logic [63:0]     r_f3;      // bytes 24-31
    logic [15:0]     r_f4;      // bytes 38-39
    logic [15:0]     r_f5;      // bytes 40-41

    logic [511:0]    w_frame;
    logic [2:0]      w_next_beat;
    logic [31:0]     w_f1;
    logic [63:0]     w_f2;
    logic [63:0]     w_f3;
    logic [15:0]     w_f4;
    logic [15:0]     w_f5;
    logic [3:0]      w_keep_cnt;
    logic            w_len_ok;
    logic [47:0]     w_sha;
    logic [31:0]     w_spa;
    logic [31:0]     w_tpa;
    logic            w_rx_match;

    assign s_axis_tready = 1'b1;

    // ------------------------------------------------------------------
    // Request frame image built from the latched addresses; byte n sits at
    // bits [8n+:8], so beat b is simply bits [64b+:64].
    // ------------------------------------------------------------------
    always_comb begin
        w_frame = '0;
        for (int i = 0; i < 6; i++) begin
            w_frame[8*i +: 8]      = 8'hFF;
            w_frame[8*(6+i) +: 8]  = r_my_mac[8*(5-i) +: 8];
            w_frame[8*(22+i) +: 8] = r_my_mac[8*(5-i) +: 8];
        end
        w_frame[8*12 +: 8] = 8'h08;
        w_frame[8*13 +: 8] = 8'h06;
        w_frame[8*14 +: 8] = 8'h00;
        w_frame[8*15 +: 8] = 8'h01;
        w_frame[8*16 +: 8] = 8'h08;
        w_frame[8*17 +: 8] = 8'h00;
        w_frame[8*18 +: 8] = 8'h06;
        w_frame[8*19 +: 8] = 8'h04;
        w_frame[8*20 +: 8] = 8'h00;
        w_frame[8*21 +: 8] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            w_frame[8*(28+i) +: 8] = r_my_ip[8*(3-i) +: 8];
            w_frame[8*(38+i) +: 8] = r_target_ip[8*(3-i) +: 8];
        end
    end

    assign w_next_beat = r_tx_beat + 3'd1;

    // ------------------------------------------------------------------
    // Rx parser. The beat that carries tlast has not been stored yet, so
    // each field is taken from the live bus when the index points at it.
    // ------------------------------------------------------------------
    assign w_f1 = (r_rx_idx == 8'd1) ? s_axis_tdata[63:32] : r_f1;
    assign w_f2 = (r_rx_idx == 8'd2) ? s_axis_tdata        : r_f2;
    assign w_f3 = (r_rx_idx == 8'd3) ? s_axis_tdata        : r_f3;
    assign w_f4 = (r_rx_idx == 8'd4) ? s_axis_tdata[63:48] : r_f4;
    assign w_f5 = (r_rx_idx == 8'd5) ? s_axis_tdata[15:0]  : r_f5;

    always_comb begin
        w_keep_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            w_keep_cnt = w_keep_cnt + {3'd0, s_axis_tkeep[i]};
        end
    end

    // Length >= 42 needs at least beat index 5 with two valid lanes.
    assign w_len_ok = (r_rx_idx > 8'd5) || ((r_rx_idx == 8'd5) && (w_keep_cnt >= 4'd2));

    assign w_sha = {w_f2[55:48], w_f2[63:56], w_f3[7:0], w_f3[15:8], w_f3[23:16], w_f3[31:24]};
    assign w_spa = {w_f3[39:32], w_f3[47:40], w_f3[55:48], w_f3[63:56]};
    assign w_tpa = {w_f4[7:0], w_f4[15:8], w_f5[7:0], w_f5[15:8]};

    // Constants are the byte fields in lane order (lowest byte first).
    assign w_rx_match = s_axis_tvalid && s_axis_tlast && w_len_ok
                     && (w_f1 == 32'h0100_0608)
                     && (w_f2[47:0] == 48'h0200_0406_0008)
                     && (w_spa == r_target_ip)
                     && (w_tpa == r_my_ip);

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            r_rx_idx <= '0;
            r_f1     <= '0;
            r_f2     <= '0;
            r_f3     <= '0;
            r_f4     <= '0;
            r_f5     <= '0;
        end else if (s_axis_tvalid) begin
            case (r_rx_idx)
                8'd1:    r_f1 <= s_axis_tdata[63:32];
                8'd2:    r_f2 <= s_axis_tdata;
                8'd3:    r_f3 <= s_axis_tdata;
                8'd4:    r_f4 <= s_axis_tdata[63:48];
                8'd5:    r_f5 <= s_axis_tdata[15:0];
                default: ;
            endcase
            if (s_axis_tlast) begin
                r_rx_idx <= '0;
            end else if (r_rx_idx != 8'hFF) begin
                r_rx_idx <= r_rx_idx + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            r_state       <= IDLE;
            r_my_mac      <= '0;
            r_my_ip       <= '0;
            r_target_ip   <= '0;
            r_attempts    <= '0;
            r_timer       <= '0;
            r_tx_beat     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            resolved_mac  <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_my_mac      <= my_mac;
                        r_my_ip       <= my_ip;
                        r_target_ip   <= target_ip;
                        r_attempts    <= '0;
                        r_tx_beat     <= '0;
                        busy          <= 1'b1;
                        // Beat 0 comes straight from the ports since the
                        // latched copies are only written on this edge.
                        m_axis_tdata  <= {my_mac[39:32], my_mac[47:40], 48'hFFFF_FFFF_FFFF};
                        m_axis_tkeep  <= 8'hFF;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tvalid <= 1'b1;
                        r_state       <= SEND;
                    end
                end
                SEND: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        if (r_tx_beat == 3'd7) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tkeep  <= '0;
                            m_axis_tdata  <= '0;
                            r_timer       <= '0;
                            r_state       <= WAIT;
                        end else begin
                            r_tx_beat     <= w_next_beat;
                            m_axis_tdata  <= w_frame[{w_next_beat, 6'd0} +: 64];
                            m_axis_tkeep  <= (w_next_beat == 3'd7) ? 8'h0F : 8'hFF;
                            m_axis_tlast  <= (w_next_beat == 3'd7);
                        end
                    end
                end
                WAIT: begin
                    // A reply wins over a timeout landing on the same cycle.
                    if (w_rx_match) begin
                        resolved_mac <= w_sha;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        r_state      <= IDLE;
                    end else if (r_timer == c_timer_last) begin
                        if (r_attempts < c_max_retries) begin
                            r_attempts    <= r_attempts + 8'd1;
                            r_tx_beat     <= '0;
                            m_axis_tdata  <= w_frame[63:0];
                            m_axis_tkeep  <= 8'hFF;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tvalid <= 1'b1;
                            r_state       <= SEND;
                        end else begin
                            error   <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arp_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_arp_requester
// Purpose  : Directed self-checking bench for arp_requester (TIMEOUT=50,
//            MAX_RETRIES=1): request frame contents, reply matching, filters,
//            retry/timeout, backpressure, coincident events and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arp_requester;

    localparam logic [47:0] MY_MAC = 48'h0211_2233_4455;
    localparam logic [31:0] MY_IP  = 32'hC0A8_0A02;
    localparam logic [31:0] TGT_IP = 32'hC0A8_0A01;

    logic        bus_clk;
    logic        bus_rst;
    logic [47:0] my_mac;
    logic [31:0] my_ip;
    logic [31:0] target_ip;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [47:0] resolved_mac;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;

    int checks;
    int errors;

    logic [63:0] exp_tx [0:7];
    logic [7:0]  rb     [0:63];

    arp_requester #(
        .TIMEOUT     (50),
        .MAX_RETRIES (1)
    ) dut (
        .bus_clk       (bus_clk),
        .bus_rst       (bus_rst),
        .my_mac        (my_mac),
        .my_ip         (my_ip),
        .target_ip     (target_ip),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .resolved_mac  (resolved_mac),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Build an ARP reply-shaped frame into rb[].
    task automatic build_reply(input logic [47:0] sha, input logic [31:0] spa,
                               input logic [31:0] tpa, input logic [15:0] etype,
                               input logic [15:0] op);
        for (int i = 0; i < 64; i++) rb[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            rb[i]      = MY_MAC[8*(5-i) +: 8];
            rb[6+i]    = sha[8*(5-i) +: 8];
            rb[22+i]   = sha[8*(5-i) +: 8];
            rb[32+i]   = MY_MAC[8*(5-i) +: 8];
        end
        rb[12] = etype[15:8]; rb[13] = etype[7:0];
        rb[14] = 8'h00;       rb[15] = 8'h01;
        rb[16] = 8'h08;       rb[17] = 8'h00;
        rb[18] = 8'h06;       rb[19] = 8'h04;
        rb[20] = op[15:8];    rb[21] = op[7:0];
        for (int i = 0; i < 4; i++) begin
            rb[28+i] = spa[8*(3-i) +: 8];
            rb[38+i] = tpa[8*(3-i) +: 8];
        end
    endtask

    // Drive rb[0..nbytes-1] on the ingress; returns on the negedge after the
    // final beat was taken.
    task automatic send_rx(input int nbytes, input logic with_last);
        int          nb;
        logic [63:0] d;
        logic [7:0]  k;
        nb = (nbytes + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            k = '0;
            for (int l = 0; l < 8; l++) begin
                if (8*b + l < nbytes) begin
                    d[8*l +: 8] = rb[8*b + l];
                    k[l]        = 1'b1;
                end
            end
            s_axis_tdata  = d;
            s_axis_tkeep  = k;
            s_axis_tlast  = with_last && (b == nb - 1);
            s_axis_tvalid = 1'b1;
            @(negedge bus_clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Collect one 8-beat request frame with tready high duty% of cycles,
    // checking that stalled beats stay put, then compare to exp_tx.
    task automatic capture_tx(input int duty, input string tag);
        int          n;
        int          cyc;
        logic        stalled;
        logic [63:0] pd;
        logic [7:0]  pk;
        logic        pl;
        logic [63:0] cd [0:7];
        logic [7:0]  ck [0:7];
        logic        cl [0:7];
        for (int i = 0; i < 8; i++) begin
            cd[i] = 'x; ck[i] = 'x; cl[i] = 1'bx;
        end
        n = 0; cyc = 0; stalled = 1'b0; pd = '0; pk = '0; pl = 1'b0;
        while (n < 8 && cyc < 400) begin
            m_axis_tready = ($urandom_range(0, 99) < duty);
            if (stalled) begin
                chk($sformatf("%s hold valid", tag), 64'(m_axis_tvalid), 64'd1);
                chk($sformatf("%s hold data", tag), m_axis_tdata, pd);
                chk($sformatf("%s hold keep/last", tag), 64'({m_axis_tkeep, m_axis_tlast}), 64'({pk, pl}));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                cd[n] = m_axis_tdata; ck[n] = m_axis_tkeep; cl[n] = m_axis_tlast;
                n++;
                stalled = 1'b0;
            end else if (m_axis_tvalid) begin
                stalled = 1'b1;
                pd = m_axis_tdata; pk = m_axis_tkeep; pl = m_axis_tlast;
            end
            @(negedge bus_clk);
            cyc++;
        end
        m_axis_tready = 1'b1;
        chk($sformatf("%s beat count", tag), 64'(n), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s beat%0d data", tag, i), cd[i], exp_tx[i]);
            chk($sformatf("%s beat%0d keep", tag, i), 64'(ck[i]), (i == 7) ? 64'h0F : 64'hFF);
            chk($sformatf("%s beat%0d last", tag, i), 64'(cl[i]), (i == 7) ? 64'd1 : 64'd0);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge bus_clk);
        start = 1'b0;
    endtask

    initial begin
        int k;
        int extra;
        checks = 0;
        errors = 0;

        // Hand-computed request beats for 02:11:22:33:44:55 / .10.2 -> .10.1
        exp_tx[0] = 64'h1102_FFFF_FFFF_FFFF;
        exp_tx[1] = 64'h0100_0608_5544_3322;
        exp_tx[2] = 64'h1102_0100_0406_0008;
        exp_tx[3] = 64'h020A_A8C0_5544_3322;
        exp_tx[4] = 64'hA8C0_0000_0000_0000;
        exp_tx[5] = 64'h0000_0000_0000_010A;
        exp_tx[6] = 64'h0000_0000_0000_0000;
        exp_tx[7] = 64'h0000_0000_0000_0000;

        bus_rst = 1'b1; start = 1'b0;
        my_mac = MY_MAC; my_ip = MY_IP; target_ip = TGT_IP;
        m_axis_tready = 1'b1;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
        repeat (3) @(negedge bus_clk);

        // ---- reset state ----
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done/error", 64'({done, error}), 64'd0);
        chk("rst resolved_mac", 64'(resolved_mac), 64'd0);
        chk("rst tvalid/tlast", 64'({m_axis_tvalid, m_axis_tlast}), 64'd0);
        chk("rst tkeep", 64'(m_axis_tkeep), 64'd0);
        chk("rst tdata", m_axis_tdata, 64'd0);
        chk("rst s_tready", 64'(s_axis_tready), 64'd1);
        bus_rst = 1'b0;
        @(negedge bus_clk);

        // ---- request, unstalled ----
        pulse_start();
        chk("req busy", 64'(busy), 64'd1);
        chk("req tvalid first cycle", 64'(m_axis_tvalid), 64'd1);
        capture_tx(100, "req");

        // ---- matching reply ----
        build_reply(48'h0080_2FAA_BBCC, TGT_IP, MY_IP, 16'h0806, 16'h0002);
        send_rx(60, 1'b1);
        chk("reply done", 64'(done), 64'd1);
        chk("reply busy", 64'(busy), 64'd0);
        chk("reply mac", 64'(resolved_mac), 64'h0080_2FAA_BBCC);
        @(negedge bus_clk);
        chk("reply done one cycle", 64'(done), 64'd0);

        // ---- non-matching frames, retry, error ----
        pulse_start();
        capture_tx(100, "nm req1");
        build_reply(48'h0080_2F00_0001, 32'hC0A8_0A07, MY_IP, 16'h0806, 16'h0002);
        send_rx(60, 1'b1);
        chk("wrong spa no done", 64'(done), 64'd0);
        build_reply(48'h0080_2F00_0002, TGT_IP, MY_IP, 16'h0806, 16'h0001);
        send_rx(60, 1'b1);
        chk("opcode 1 no done", 64'(done), 64'd0);
        build_reply(48'h0080_2F00_0003, TGT_IP, MY_IP, 16'h0800, 16'h0002);
        send_rx(60, 1'b1);
        chk("ethertype 0800 no done", 64'(done), 64'd0);
        build_reply(48'h0080_2F00_0004, TGT_IP, MY_IP, 16'h0806, 16'h0002);
        send_rx(40, 1'b1);
        chk("40 byte no done", 64'(done), 64'd0);
        chk("nm still busy", 64'(busy), 64'd1);
        capture_tx(100, "nm retry");
        k = 0; extra = 0;
        while (!error && k < 200) begin
            if (m_axis_tvalid) extra++;
            if (done) extra++;
            @(negedge bus_clk);
            k++;
        end
        chk("error latency", 64'(k), 64'd50);
        chk("no third request", 64'(extra), 64'd0);
        chk("error busy", 64'(busy), 64'd0);
        chk("error keeps mac", 64'(resolved_mac), 64'h0080_2FAA_BBCC);
        @(negedge bus_clk);
        chk("error one cycle", 64'(error), 64'd0);

        // ---- backpressure, then reply on the timeout cycle ----
        pulse_start();
        capture_tx(30, "bp");
        capture_tx(100, "bp retry");
        repeat (42) @(negedge bus_clk);
        chk("pre-coincide no error", 64'({done, error}), 64'd0);
        build_reply(48'h0080_2F01_0203, TGT_IP, MY_IP, 16'h0806, 16'h0002);
        send_rx(60, 1'b1);
        chk("coincide done", 64'(done), 64'd1);
        chk("coincide error", 64'(error), 64'd0);
        chk("coincide mac", 64'(resolved_mac), 64'h0080_2F01_0203);
        @(negedge bus_clk);
        chk("coincide later error", 64'(error), 64'd0);

        // ---- start while busy is ignored ----
        pulse_start();
        capture_tx(100, "busy req");
        target_ip = 32'h0A00_0009;
        pulse_start();
        target_ip = TGT_IP;
        repeat (3) @(negedge bus_clk);
        chk("busy start no tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("busy start busy", 64'(busy), 64'd1);
        build_reply(48'h0080_2FAA_BBCC, TGT_IP, MY_IP, 16'h0806, 16'h0002);
        send_rx(60, 1'b1);
        chk("busy start done", 64'(done), 64'd1);
        chk("busy start mac", 64'(resolved_mac), 64'h0080_2FAA_BBCC);

        // ---- reset mid-frame (tx at beat 3, rx partway through a frame) ----
        @(negedge bus_clk);
        send_rx(24, 1'b0);
        pulse_start();
        repeat (3) @(negedge bus_clk);
        chk("at beat3 data", m_axis_tdata, exp_tx[3]);
        bus_rst = 1'b1;
        @(negedge bus_clk);
        chk("mid rst busy", 64'(busy), 64'd0);
        chk("mid rst done/error", 64'({done, error}), 64'd0);
        chk("mid rst mac", 64'(resolved_mac), 64'd0);
        chk("mid rst tvalid/tlast", 64'({m_axis_tvalid, m_axis_tlast}), 64'd0);
        chk("mid rst tkeep", 64'(m_axis_tkeep), 64'd0);
        chk("mid rst tdata", m_axis_tdata, 64'd0);
        chk("mid rst s_tready", 64'(s_axis_tready), 64'd1);
        bus_rst = 1'b0;
        repeat (3) @(negedge bus_clk);
        chk("post rst no tvalid", 64'(m_axis_tvalid), 64'd0);
        pulse_start();
        capture_tx(100, "fresh");
        build_reply(48'h0080_2FAA_BBCC, TGT_IP, MY_IP, 16'h0806, 16'h0002);
        send_rx(60, 1'b1);
        chk("fresh done", 64'(done), 64'd1);
        chk("fresh mac", 64'(resolved_mac), 64'h0080_2FAA_BBCC);

        repeat (2) @(negedge bus_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
